// File: rtl/mem_port_arbiter_if.sv
// mem_port_if: request/response port bundle between a requester and a memory port
interface mem_port_if #(parameter int AW = 32, parameter int DW = 32);
  logic req_valid;
  logic req_ready;
  logic [AW-1:0] addr;
  logic wen;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wmask;
  logic resp_valid;
  logic resp_ready;
  logic [DW-1:0] rdata;
  logic resp_err;
  modport master(output req_valid, addr, wen, wdata, wmask, resp_ready,
                 input req_ready, resp_valid, rdata, resp_err);
  modport slave(input req_valid, addr, wen, wdata, wmask, resp_ready,
                output req_ready, resp_valid, rdata, resp_err);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between IFU (m0) and LSU (m1) with response watchdog
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 1024
) (
  input logic clk,
  input logic rst_n,
  mem_port_if.slave m0,
  mem_port_if.slave m1,
  mem_port_if.master s,
  output logic grant,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;
  state_t state;
  logic last_grant;
  logic [15:0] cnt;
  logic in_req, in_resp, in_err, win_rr, timeout_hit;
  assign in_req = state == REQ;
  assign in_resp = state == RESP;
  assign in_err = state == ERR;
  assign win_rr = grant ? m1.resp_ready : m0.resp_ready;
  assign timeout_hit = TIMEOUT != 0 && cnt == 16'(TIMEOUT - 1) && !s.resp_valid;
  // Arbitration, transaction sequencing and the response watchdog counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= 1'b0;
      last_grant <= 1'b1;
      cnt <= '0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (m0.req_valid || m1.req_valid) begin
          grant <= (m0.req_valid && m1.req_valid) ? ~last_grant : m1.req_valid;
          state <= REQ;
          busy <= 1'b1;
        end
        REQ: if (s.req_ready) begin
          state <= RESP;
          cnt <= '0;
        end
        RESP: if (s.resp_valid && win_rr) begin
          last_grant <= grant;
          state <= IDLE;
          busy <= 1'b0;
        end else if (timeout_hit) begin
          state <= ERR;
        end else if (!s.resp_valid && cnt != '1) begin
          cnt <= cnt + 16'd1;
        end
        ERR: if (win_rr) begin
          last_grant <= grant;
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign s.req_valid = in_req;
  assign s.addr = in_req ? (grant ? m1.addr : m0.addr) : '0;
  assign s.wen = in_req & (grant ? m1.wen : m0.wen);
  assign s.wdata = in_req ? (grant ? m1.wdata : m0.wdata) : '0;
  assign s.wmask = in_req ? (grant ? m1.wmask : m0.wmask) : '0;
  assign s.resp_ready = in_resp ? win_rr : 1'b1;
  assign m0.req_ready = in_req & ~grant & s.req_ready;
  assign m1.req_ready = in_req & grant & s.req_ready;
  assign m0.resp_valid = ~grant & ((in_resp & s.resp_valid) | in_err);
  assign m1.resp_valid = grant & ((in_resp & s.resp_valid) | in_err);
  assign m0.rdata = (in_resp & ~grant) ? s.rdata : '0;
  assign m1.rdata = (in_resp & grant) ? s.rdata : '0;
  assign m0.resp_err = in_err & ~grant;
  assign m1.resp_err = in_err & grant;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, routing, backpressure, timeout and reset
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic grant, busy;
  int checks = 0;
  int errors = 0;
  int req_hs = 0;
  int resp_hs = 0;
  int req_hs0, resp_hs0;
  mem_port_if #(32, 32) m0_if();
  mem_port_if #(32, 32) m1_if();
  mem_port_if #(32, 32) s_if();
  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_if.slave), .m1(m1_if.slave),
    .s(s_if.master), .grant(grant), .busy(busy)
  );
  always #5 clk = ~clk;
  // Handshake counters used by the backpressure step
  always @(posedge clk) begin
    if (s_if.req_valid && s_if.req_ready) req_hs <= req_hs + 1;
    if (m0_if.resp_valid && m0_if.resp_ready) resp_hs <= resp_hs + 1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask
  initial begin
    logic g;
    rst_n = 1'b0;
    m0_if.req_valid = 0; m0_if.addr = 0; m0_if.wen = 0; m0_if.wdata = 0; m0_if.wmask = 0; m0_if.resp_ready = 0;
    m1_if.req_valid = 0; m1_if.addr = 0; m1_if.wen = 0; m1_if.wdata = 0; m1_if.wmask = 0; m1_if.resp_ready = 0;
    s_if.req_ready = 0; s_if.resp_valid = 0; s_if.rdata = 0; s_if.resp_err = 0;
    #3;
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_s_req_valid", 32'(s_if.req_valid), 0);
    check("rst_s_resp_ready", 32'(s_if.resp_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    // single m0 read
    @(negedge clk);
    m0_if.req_valid = 1; m0_if.addr = 32'h8000_0000; s_if.req_ready = 1; m0_if.resp_ready = 1; m1_if.resp_ready = 1;
    #1 check("t1_idle_s_req_valid", 32'(s_if.req_valid), 0);
    @(negedge clk);
    check("t1_s_req_valid", 32'(s_if.req_valid), 1);
    check("t1_s_addr", s_if.addr, 32'h8000_0000);
    check("t1_m0_req_ready", 32'(m0_if.req_ready), 1);
    @(negedge clk);
    m0_if.req_valid = 0;
    check("t1_wait_resp_valid", 32'(m0_if.resp_valid), 0);
    @(negedge clk);
    s_if.resp_valid = 1; s_if.rdata = 32'hDEAD_BEEF;
    #1 check("t1_m0_resp_valid", 32'(m0_if.resp_valid), 1);
    check("t1_m0_rdata", m0_if.rdata, 32'hDEAD_BEEF);
    check("t1_m1_resp_valid", 32'(m1_if.resp_valid), 0);
    check("t1_m1_rdata", m1_if.rdata, 0);
    check("t1_grant", 32'(grant), 0);
    @(negedge clk);
    s_if.resp_valid = 0;
    check("t1_done_busy", 32'(busy), 0);
    // contention from reset, both held for four transactions
    pulse_reset();
    m0_if.req_valid = 1; m0_if.addr = 32'h100; m1_if.req_valid = 1; m1_if.addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      g = 1'(i % 2);
      @(negedge clk);
      check("t2_grant", 32'(grant), 32'(g));
      check("t2_s_addr", s_if.addr, g ? 32'h200 : 32'h100);
      check("t2_loser_req_ready", 32'(g ? m0_if.req_ready : m1_if.req_ready), 0);
      @(negedge clk);
      s_if.resp_valid = 1; s_if.rdata = 32'hA0 + 32'(i);
      #1 check("t2_win_rdata", g ? m1_if.rdata : m0_if.rdata, 32'hA0 + 32'(i));
      check("t2_win_resp_valid", 32'(g ? m1_if.resp_valid : m0_if.resp_valid), 1);
      check("t2_lose_resp_valid", 32'(g ? m0_if.resp_valid : m1_if.resp_valid), 0);
      check("t2_lose_rdata", g ? m0_if.rdata : m1_if.rdata, 0);
      @(negedge clk);
      s_if.resp_valid = 0;
    end
    m0_if.req_valid = 0; m1_if.req_valid = 0;
    // m1 write waits while m0 is in RESP
    @(negedge clk);
    m0_if.req_valid = 1; m0_if.addr = 32'h300;
    @(negedge clk);
    check("t3_m0_grant", 32'(grant), 0);
    @(negedge clk);
    m0_if.req_valid = 0;
    m1_if.req_valid = 1; m1_if.addr = 32'h400; m1_if.wen = 1; m1_if.wmask = 4'h3; m1_if.wdata = 32'h1234;
    #1 check("t3_m1_blocked_a", 32'(m1_if.req_ready), 0);
    check("t3_busy", 32'(busy), 1);
    @(negedge clk);
    check("t3_m1_blocked_b", 32'(m1_if.req_ready), 0);
    s_if.resp_valid = 1; s_if.rdata = 32'h33;
    @(negedge clk);
    s_if.resp_valid = 0;
    check("t3_m1_blocked_idle", 32'(m1_if.req_ready), 0);
    @(negedge clk);
    check("t3_grant", 32'(grant), 1);
    check("t3_s_wen", 32'(s_if.wen), 1);
    check("t3_s_wmask", 32'(s_if.wmask), 32'h3);
    check("t3_s_wdata", s_if.wdata, 32'h1234);
    check("t3_m1_req_ready", 32'(m1_if.req_ready), 1);
    @(negedge clk);
    m1_if.req_valid = 0; m1_if.wen = 0; m1_if.wmask = 0;
    s_if.resp_valid = 1; s_if.rdata = 0;
    #1 check("t3_m1_resp_valid", 32'(m1_if.resp_valid), 1);
    @(negedge clk);
    s_if.resp_valid = 0;
    // backpressure on both request and response
    req_hs0 = req_hs; resp_hs0 = resp_hs;
    s_if.req_ready = 0;
    m0_if.req_valid = 1; m0_if.addr = 32'h500; m0_if.wen = 1; m0_if.wdata = 32'hCAFE; m0_if.wmask = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_s_addr_stable", s_if.addr, 32'h500);
      check("t4_s_wdata_stable", s_if.wdata, 32'hCAFE);
      check("t4_m0_req_ready", 32'(m0_if.req_ready), 0);
    end
    s_if.req_ready = 1;
    @(negedge clk);
    s_if.req_ready = 0; m0_if.req_valid = 0; m0_if.wen = 0; m0_if.wmask = 0;
    s_if.resp_valid = 1; s_if.rdata = 32'h77; m0_if.resp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check("t4_resp_held", 32'(m0_if.resp_valid), 1);
      check("t4_s_resp_ready", 32'(s_if.resp_ready), 0);
      @(negedge clk);
    end
    m0_if.resp_ready = 1;
    @(negedge clk);
    s_if.resp_valid = 0;
    check("t4_req_handshakes", 32'(req_hs - req_hs0), 1);
    check("t4_resp_handshakes", 32'(resp_hs - resp_hs0), 1);
    // watchdog timeout
    s_if.req_ready = 1; s_if.rdata = 32'hFFFF_FFFF;
    m0_if.req_valid = 1; m0_if.addr = 32'h600;
    @(negedge clk);
    @(negedge clk);
    m0_if.req_valid = 0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    check("t5_no_early_resp", 32'(m0_if.resp_valid), 0);
    check("t5_busy", 32'(busy), 1);
    @(negedge clk);
    check("t5_err_valid", 32'(m0_if.resp_valid), 1);
    check("t5_err_flag", 32'(m0_if.resp_err), 1);
    check("t5_err_rdata", m0_if.rdata, 0);
    check("t5_err_s_resp_ready", 32'(s_if.resp_ready), 1);
    @(negedge clk);
    check("t5_back_idle", 32'(busy), 0);
    // stray response drained, then a normal m1 read
    s_if.resp_valid = 1;
    #1 check("t6_drain_ready", 32'(s_if.resp_ready), 1);
    check("t6_m0_quiet", 32'(m0_if.resp_valid), 0);
    check("t6_m1_quiet", 32'(m1_if.resp_valid), 0);
    @(negedge clk);
    s_if.resp_valid = 0;
    m1_if.req_valid = 1; m1_if.addr = 32'h700;
    @(negedge clk);
    check("t6_grant", 32'(grant), 1);
    @(negedge clk);
    m1_if.req_valid = 0;
    s_if.resp_valid = 1; s_if.rdata = 32'h1111;
    #1 check("t6_m1_rdata", m1_if.rdata, 32'h1111);
    check("t6_m1_err", 32'(m1_if.resp_err), 0);
    @(negedge clk);
    s_if.resp_valid = 0;
    // reset while in RESP
    m1_if.req_valid = 1; m1_if.addr = 32'h800;
    @(negedge clk);
    @(negedge clk);
    m1_if.req_valid = 0;
    s_if.resp_valid = 1; s_if.rdata = 32'h2222;
    #1 check("t7_pre_resp_valid", 32'(m1_if.resp_valid), 1);
    #1 rst_n = 1'b0;
    #1 check("t7_busy", 32'(busy), 0);
    check("t7_m1_resp_valid", 32'(m1_if.resp_valid), 0);
    check("t7_grant", 32'(grant), 0);
    check("t7_s_req_valid", 32'(s_if.req_valid), 0);
    @(negedge clk);
    s_if.resp_valid = 0;
    rst_n = 1'b1;
    m0_if.req_valid = 1; m1_if.req_valid = 1;
    @(negedge clk);
    check("t7_first_tie", 32'(grant), 0);
    m0_if.req_valid = 0; m1_if.req_valid = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port (SRAM/bus subordinate) between two requesters: m0 = IFU and m1 = LSU.
- Provides round-robin arbitration with one transaction outstanding at a time.
- Muxes the winner's request onto the subordinate and routes the response back to the winner only.
- Includes a response-timeout watchdog that returns an error response instead of hanging the core.

Parameters:
AW, 32, address width
DW, 32, data width (multiple of 8)
TIMEOUT, 1024, cycles to wait for s_resp_valid after request handshake; 0 disables watchdog (max 65535)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
mX_req_valid (X=0,1)  input  1  request valid; must stay high with stable fields until mX_req_ready
mX_req_ready  output  1  request accepted
mX_addr  input  AW  request address
mX_wen  input  1  1=write, 0=read
mX_wdata  input  DW  write data
mX_wmask  input  DW/8  byte write strobes
mX_resp_valid  output  1  response valid
mX_resp_ready  input  1  master accepts response
mX_rdata  output  DW  read data (0 on writes/errors)
mX_resp_err  output  1  response is timeout error
s_req_valid  output  1  request to subordinate
s_req_ready  input  1  subordinate accepts request
s_addr / s_wen / s_wdata / s_wmask  output  AW/1/DW/DW/8  muxed request fields
s_resp_valid  input  1  subordinate response valid
s_resp_ready  output  1  arbiter accepts response
s_rdata  input  DW  subordinate read data
grant  output  1  index of current/last granted master
busy  output  1  state != IDLE

Behaviour:
- FSM states IDLE, REQ, RESP, ERR; state and outputs are registered where listed.
- Reset (async, rst_n=0): state=IDLE, grant=0, last_grant=1 (so m0 wins first tie), timeout counter=0, busy=0.
- All combinational outputs are 0 during reset, except s_resp_ready, which follows the IDLE rule below.

IDLE:
- No master ready/resp_valid asserted; s_req_valid=0; s_addr/s_wen/s_wdata/s_wmask = 0.
- s_resp_ready=1, so stray late responses are drained and discarded.
- If exactly one mX_req_valid=1: grant<=X.
- If both are valid: grant<=~last_grant.
- Next state is REQ. This arbitration cycle is mandatory, so minimum request latency is 1 cycle from valid to s_req_valid.

REQ:
- s_req_valid=1; s_* fields = granted master's fields, combinational mux on grant.
- m[grant]_req_ready = s_req_ready; the other master's req_ready=0.
- s_resp_ready=1 (stray drain).
- On s_req_ready=1: next state RESP, counter<=0.

RESP:
- m[grant]_resp_valid = s_resp_valid; m[grant]_rdata = s_rdata; resp_err=0.
- s_resp_ready = m[grant]_resp_ready; the non-granted master sees resp_valid=0 and rdata=0.
- Counter increments each cycle s_resp_valid=0, saturating.
- On s_resp_valid & m[grant]_resp_ready: last_grant<=grant, next state IDLE.
- If TIMEOUT!=0 and counter reaches TIMEOUT-1 with no s_resp_valid: next state ERR.

ERR:
- m[grant]_resp_valid=1, resp_err=1, rdata=0; s_resp_ready=1 (drain).
- On m[grant]_resp_ready: last_grant<=grant, next state IDLE.

General rules:
- A request arriving while busy waits, holding valid; it cannot be lost.
- A master deasserting valid before ready is a protocol violation; behaviour is undefined, but the FSM must not deadlock.
- Reset mid-transaction aborts immediately to IDLE; the subordinate shares rst_n.
- grant changes only in IDLE.
- Back-to-back contention alternates m0, m1, m0, …

Test Plan:
- Single m0 read: m0_req_valid at cycle 0, addr=0x8000_0000; s_req_ready=1; s_resp_valid at cycle 3 with rdata=0xDEADBEEF -> s_req_valid at cycle 1, m0_resp_valid/rdata=0xDEADBEEF at cycle 3, m1 sees nothing, grant=0.
- Simultaneous requests from reset, both held continuously for 4 transactions -> grant order m0, m1, m0, m1; each master's rdata is routed only to that master.
- m1 write (wmask=0x3, wdata=0x1234) while m0 is mid-transaction in RESP -> m1_req_ready stays 0 until m0 completes; then s_wen=1, s_wmask=0x3, s_wdata=0x1234.
- Backpressure: s_req_ready low for 5 cycles, then m0_resp_ready low for 3 cycles after s_resp_valid -> fields stable throughout; exactly one request handshake and one response handshake.
- TIMEOUT=8, subordinate never responds -> m0_resp_valid=1 with resp_err=1 and rdata=0 after 8 RESP cycles.
- Timeout continuation: after the timeout, a stray s_resp_valid in IDLE is drained; the next m1 request completes normally.
- rst_n pulsed low while in RESP -> immediately (asynchronously) busy=0, all valids/readies 0; after release, m0 wins the first tie.
